// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD run sequencer and its cycle counter.
package gcd_pkg;

    localparam int GCD_CNT_W    = 12;
    localparam int GCD_OPCODE_W = 12;

    localparam logic [GCD_CNT_W-1:0] GCD_CT_BUDGET = 12'd2048;
    localparam logic [GCD_CNT_W-1:0] GCD_TIMEOUT   = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAD    = 3'd3,
        ST_DONE   = 3'd4
    } gcd_state_e;

endpackage

// File: rtl/gcd_cycle_counter.sv
// Saturating run-cycle counter with registered "count+1 == limit" flags, one per limit.
module gcd_cycle_counter #(
    parameter int CNT_W   = 12,
    parameter int NUM_LIM = 2
) (
    input  logic                            CLK,
    input  logic                            RESETn,
    input  logic                            clr,
    input  logic                            en,
    input  logic [NUM_LIM-1:0][CNT_W-1:0]   limit,
    output logic [CNT_W-1:0]                count,
    output logic [NUM_LIM-1:0]              nxt_eq
);

    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W:0]     count_inc;
    logic [NUM_LIM-1:0] nxt_eq_q, nxt_eq_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && count_q != '1)
            count_d = count_q + CNT_W'(1);
    end

    // Flags are computed from the next count so they line up with count_q next cycle.
    assign count_inc = {1'b0, count_d} + (CNT_W+1)'(1);

    for (genvar i = 0; i < NUM_LIM; i++) begin : g_lim
        assign nxt_eq_d[i] = (count_inc == {1'b0, limit[i]});
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            count_q  <= '0;
            nxt_eq_q <= '0;
        end else begin
            count_q  <= count_d;
            nxt_eq_q <= nxt_eq_d;
        end
    end

    assign count  = count_q;
    assign nxt_eq = nxt_eq_q;

endmodule

// File: rtl/gcd_run_ctrl.sv
// Run sequencer: launches the GCD core, pads constant-time runs to a fixed budget,
// and aborts runs that exceed the hang timeout.
module gcd_run_ctrl
    import gcd_pkg::*;
#(
    parameter int               CNT_W     = GCD_CNT_W,
    parameter logic [CNT_W-1:0] CT_BUDGET = GCD_CT_BUDGET,
    parameter logic [CNT_W-1:0] TIMEOUT   = GCD_TIMEOUT
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    START_PULSE,
    input  logic [GCD_OPCODE_W-1:0] OPCODE,
    input  logic                    CONSTANT_TIME,
    input  logic                    CORE_DONE,
    output logic                    CORE_START,
    output logic                    CORE_EN,
    output logic                    CORE_ABORT,
    output logic [GCD_OPCODE_W-1:0] CORE_OPCODE,
    output logic                    BUSY,
    output logic                    TIMEOUT_ERR,
    output logic                    DONE_PULSE,
    output logic [CNT_W-1:0]        CYCLE_COUNT
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [2:0] S_RUN    = ST_RUN;
    localparam logic [2:0] S_PAD    = ST_PAD;
    localparam logic [2:0] S_DONE   = ST_DONE;

    logic [2:0]              state_q, state_d;
    logic [GCD_OPCODE_W-1:0] opcode_q, opcode_d;
    logic                    ct_q, ct_d;
    logic                    err_q, err_d;
    logic                    abort_q, abort_d;
    logic                    past_q, past_d;

    logic                    cnt_clr, cnt_en;
    logic [CNT_W-1:0]        count;
    logic [1:0]              nxt_eq;
    logic [1:0][CNT_W-1:0]   lim;
    logic                    budget_left;

    assign lim    = {TIMEOUT, CT_BUDGET};
    assign cnt_en = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_PAD);

    gcd_cycle_counter #(.CNT_W(CNT_W), .NUM_LIM(2)) u_cnt (
        .CLK    (CLK),
        .RESETn (RESETn),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (lim),
        .count  (count),
        .nxt_eq (nxt_eq)
    );

    // past_q remembers that count+1 has already passed CT_BUDGET, giving count+1 < CT_BUDGET.
    assign budget_left = !nxt_eq[0] && !past_q;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        ct_d     = ct_q;
        err_d    = err_q;
        abort_d  = 1'b0;
        past_d   = past_q;
        cnt_clr  = 1'b0;
        case (state_q)
            S_IDLE: if (START_PULSE) begin
                opcode_d = OPCODE;
                ct_d     = CONSTANT_TIME;
                err_d    = 1'b0;
                past_d   = 1'b0;
                cnt_clr  = 1'b1;
                state_d  = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                if (CORE_DONE)
                    state_d = (ct_q && budget_left) ? S_PAD : S_DONE;
                else if (nxt_eq[1]) begin
                    // Abort is registered so it stays off the input-to-output path.
                    state_d = S_DONE;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_PAD:   if (nxt_eq[0]) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if ((state_q == S_LAUNCH || state_q == S_RUN) && nxt_eq[0])
            past_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            ct_q     <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            past_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ct_q     <= ct_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            past_q   <= past_d;
        end
    end

    assign CORE_START  = (state_q == S_LAUNCH);
    assign CORE_EN     = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign CORE_ABORT  = abort_q;
    assign CORE_OPCODE = opcode_q;
    assign BUSY        = (state_q != S_IDLE);
    assign TIMEOUT_ERR = err_q;
    assign DONE_PULSE  = (state_q == S_DONE);
    assign CYCLE_COUNT = count;

endmodule

// File: tb/tb_gcd_run_ctrl.sv
// Scoreboard bench for gcd_run_ctrl: a driver issues runs and queues the expected
// result, a monitor checks each DONE_PULSE against the queue.
module tb_gcd_run_ctrl;

    localparam int B = 64;
    localparam int T = 256;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic        START_PULSE = 1'b0;
    logic [11:0] OPCODE = '0;
    logic        CONSTANT_TIME = 1'b0;
    logic        CORE_DONE = 1'b0;
    logic        CORE_START, CORE_EN, CORE_ABORT, BUSY, TIMEOUT_ERR, DONE_PULSE;
    logic [11:0] CORE_OPCODE;
    logic [11:0] CYCLE_COUNT;

    gcd_run_ctrl #(.CNT_W(12), .CT_BUDGET(12'd64), .TIMEOUT(12'd256)) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .START_PULSE   (START_PULSE),
        .OPCODE        (OPCODE),
        .CONSTANT_TIME (CONSTANT_TIME),
        .CORE_DONE     (CORE_DONE),
        .CORE_START    (CORE_START),
        .CORE_EN       (CORE_EN),
        .CORE_ABORT    (CORE_ABORT),
        .CORE_OPCODE   (CORE_OPCODE),
        .BUSY          (BUSY),
        .TIMEOUT_ERR   (TIMEOUT_ERR),
        .DONE_PULSE    (DONE_PULSE),
        .CYCLE_COUNT   (CYCLE_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] opc;
        int          cnt;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   abort_cnt = 0;
    int   done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DONE_PULSE must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESETn) begin
                if (CORE_START) abort_cnt = 0;
                if (CORE_ABORT) abort_cnt++;
                if (DONE_PULSE) begin
                    done_seen++;
                    if (sb.size() == 0)
                        chk("unexpected_done", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("core_opcode", CORE_OPCODE, e.opc);
                        chk("cycle_count", CYCLE_COUNT, e.cnt);
                        chk("timeout_err", TIMEOUT_ERR, e.err);
                        chk("abort_pulses", abort_cnt, e.err ? 1 : 0);
                    end
                end
            end
        end
    end

    // k = RUN cycle on which the core reports done; 0 or >= T means it never does in time.
    task automatic run_op(input logic [11:0] opc, input bit ct, input int k, input bit noise);
        exp_t e;
        int   pad_exp, pad_seen, en_low, n;
        pad_exp = 0;
        if (k == 0 || k > T-1) begin
            e.cnt = T;
            e.err = 1'b1;
        end else begin
            e.cnt = k + 1;
            e.err = 1'b0;
            if (ct && k + 1 < B) begin
                pad_exp = B - (k + 1);
                e.cnt   = B;
            end
        end
        e.opc = opc;

        @(negedge CLK);
        chk("idle_no_start", CORE_START, 0);
        START_PULSE   = 1'b1;
        OPCODE        = opc;
        CONSTANT_TIME = ct;
        sb.push_back(e);
        @(negedge CLK);
        START_PULSE = 1'b0;
        chk("start_latency", CORE_START, 1);
        chk("launch_en", CORE_EN, 1);
        if (noise) begin
            START_PULSE   = 1'b1;
            OPCODE        = 12'hFFF;
            CONSTANT_TIME = ~ct;
            CORE_DONE     = 1'b1;
        end
        en_low = 0;
        if (k > 0 && k <= T-1) begin
            for (int j = 1; j <= k; j++) begin
                @(negedge CLK);
                START_PULSE = (noise && j == 2);
                CORE_DONE   = (j == k);
                if (!CORE_EN) en_low++;
            end
        end
        @(negedge CLK);
        CORE_DONE   = 1'b0;
        START_PULSE = 1'b0;
        pad_seen = 0;
        n = 0;
        while (BUSY && n < T + B + 10) begin
            if (!CORE_EN && !DONE_PULSE) pad_seen++;
            @(negedge CLK);
            n++;
        end
        chk("run_finished", BUSY, 0);
        chk("pad_cycles", pad_seen, pad_exp);
        chk("run_en_low", en_low, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_start"}, CORE_START, 0);
        chk({tag, "_en"}, CORE_EN, 0);
        chk({tag, "_abort"}, CORE_ABORT, 0);
        chk({tag, "_opcode"}, CORE_OPCODE, 0);
        chk({tag, "_err"}, TIMEOUT_ERR, 0);
        chk({tag, "_done"}, DONE_PULSE, 0);
        chk({tag, "_count"}, CYCLE_COUNT, 0);
    endtask

    task automatic reset_mid_run();
        int d0;
        @(negedge CLK);
        START_PULSE   = 1'b1;
        OPCODE        = 12'h3C3;
        CONSTANT_TIME = 1'b1;
        @(negedge CLK);
        START_PULSE = 1'b0;
        repeat (20) @(negedge CLK);
        chk("busy_before_reset", BUSY, 1);
        #2 RESETn = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        d0 = done_seen;
        repeat (T + B + 20) @(negedge CLK);
        chk("done_after_reset", done_seen - d0, 0);
        chk("idle_after_reset", BUSY, 0);
    endtask

    initial begin
        #1 RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);

        run_op(12'h0A5, 1'b0, 5, 1'b1);
        run_op(12'h111, 1'b1, 5, 1'b0);
        run_op(12'h222, 1'b1, 100, 1'b0);
        run_op(12'h333, 1'b0, 0, 1'b0);
        run_op(12'h444, 1'b0, 3, 1'b0);
        run_op(12'h555, 1'b1, B-1, 1'b0);
        run_op(12'h666, 1'b1, B-2, 1'b0);
        run_op(12'h777, 1'b0, T-1, 1'b0);
        run_op(12'h888, 1'b1, 0, 1'b1);
        run_op(12'h999, 1'b0, 1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            run_op(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 300)), 1'($urandom_range(0, 1)));
        end

        reset_mid_run();
        run_op(12'h0A5, 1'b0, 5, 1'b0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
